// File: rtl/splitr_pkg.sv
// splitr_pkg: shared width default, buffer depth and output-select state type for splitr.
package splitr_pkg;
   localparam int DEF_LEN = 8;
   localparam logic [1:0] DEPTH = 2'd2;
   typedef enum logic {SEL_0 = 1'b0, SEL_1 = 1'b1} sel_t;
endpackage

// File: rtl/splitr_fifo2.sv
// splitr_fifo2: 2-entry FIFO of {last,data} words, one per splitr output.
module splitr_fifo2
   import splitr_pkg::*;
#(
   parameter int W = DEF_LEN + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [W-1:0] m0, m1;
   logic         wp, rp, do_push, do_pop;

   // Pushing into a full buffer is refused even if it pops this cycle.
   always_comb begin
      do_push = push & (count < DEPTH);
      do_pop  = pop & (count != 2'd0);
      dout    = rp ? m1 : m0;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         m0    <= '0;
         m1    <= '0;
         wp    <= 1'b0;
         rp    <= 1'b0;
         count <= 2'd0;
      end else begin
         if (do_push) begin
            if (wp) m1 <= din;
            else m0 <= din;
            wp <= ~wp;
         end
         if (do_pop) rp <= ~rp;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
endmodule

// File: rtl/splitr.sv
// splitr: routes whole packets round-robin to two buffered outputs.
// Optional SPLIT_STAT_EN adds per-output completed-packet counters.
module splitr
   import splitr_pkg::*;
#(
   parameter int LEN = DEF_LEN
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid_in,
   output logic           ready_in,
   input  logic [LEN-1:0] data_in,
   input  logic           last_in,
   output logic           valid_0,
   input  logic           ready_0,
   output logic [LEN-1:0] data_0,
   output logic           last_0,
   output logic           valid_1,
   input  logic           ready_1,
   output logic [LEN-1:0] data_1,
   output logic           last_1
`ifdef SPLIT_STAT_EN
   ,
   output logic [7:0]     pkt_cnt_0,
   output logic [7:0]     pkt_cnt_1
`endif
);
   sel_t       sel, sel_n;
   logic [1:0] cnt_0, cnt_1;
   logic       acc, push_0, push_1;

   always_ff @(posedge clk or negedge rst)
      if (!rst) sel <= SEL_0;
      else sel <= sel_n;

   // ready_in looks only at registered counts, never at ready_0/ready_1.
   always_comb begin
      ready_in = rst & (((sel == SEL_0) ? cnt_0 : cnt_1) < DEPTH);
      acc      = valid_in & ready_in;
      push_0   = acc & (sel == SEL_0);
      push_1   = acc & (sel == SEL_1);
      sel_n    = (acc & last_in) ? ((sel == SEL_0) ? SEL_1 : SEL_0) : sel;
   end

   splitr_fifo2 #(.W(LEN + 1)) u_fifo_0 (
      .clk  (clk),
      .rst  (rst),
      .push (push_0),
      .pop  (valid_0 & ready_0),
      .din  ({last_in, data_in}),
      .dout ({last_0, data_0}),
      .count(cnt_0)
   );

   splitr_fifo2 #(.W(LEN + 1)) u_fifo_1 (
      .clk  (clk),
      .rst  (rst),
      .push (push_1),
      .pop  (valid_1 & ready_1),
      .din  ({last_in, data_in}),
      .dout ({last_1, data_1}),
      .count(cnt_1)
   );

   assign valid_0 = |cnt_0;
   assign valid_1 = |cnt_1;

`ifdef SPLIT_STAT_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         pkt_cnt_0 <= 8'd0;
         pkt_cnt_1 <= 8'd0;
      end else begin
         if (valid_0 & ready_0 & last_0) pkt_cnt_0 <= pkt_cnt_0 + 8'd1;
         if (valid_1 & ready_1 & last_1) pkt_cnt_1 <= pkt_cnt_1 + 8'd1;
      end
`endif
endmodule
